// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM state
// encoding, access-size type and funct3 decode helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // Illegal codes fall back to a word access.
  function automatic size_e f3_size(input logic we, input logic [2:0] f3);
    size_e sz;
    sz = SZ_WORD;
    if (f3_legal(we, f3)) begin
      case (f3[1:0])
        2'b00:   sz = SZ_BYTE;
        2'b01:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path alignment: picks the addressed byte/halfword lane out of a
// 32-bit little-endian word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    byte_val = word[8*offset +: 8];
    half_val = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: data = {{16{sign_ext & half_val[15]}}, half_val};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32I data-memory controller: valid/ready request, fixed-latency response,
// byte-enabled word array. Define DMEM_ERR_CHECK_EN to fault bad accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int SIZE_BYTES = 4096,
  parameter int LATENCY    = 1
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW    = $clog2(SIZE_BYTES);
  localparam int WORDS = SIZE_BYTES / 4;
  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        we_reg;
  logic [2:0]  f3_reg;
  logic [31:0] addr_reg, wdata_reg;

  logic        accept, fire;
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr, acc_wdata;
  size_e       acc_size;
  logic [1:0]  acc_off;
  logic        acc_err;
  logic [AW-3:0] acc_idx;
  logic [3:0]  be;
  logic [31:0] wd;

  logic [31:0] mem [0:WORDS-1];

  logic [31:0] rd_word_reg;
  logic [1:0]  ld_off_reg;
  size_e       ld_size_reg;
  logic        ld_sign_reg;
  logic        ld_ok_reg;
  logic [31:0] aligned;

  assign req_ready = (state_reg == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With zero latency the access happens on the accept edge, so use live inputs.
  assign acc_we    = (state_reg == ST_IDLE) ? req_we     : we_reg;
  assign acc_f3    = (state_reg == ST_IDLE) ? req_funct3 : f3_reg;
  assign acc_addr  = (state_reg == ST_IDLE) ? req_addr   : addr_reg;
  assign acc_wdata = (state_reg == ST_IDLE) ? req_wdata  : wdata_reg;

  assign fire = !rst && ((accept && (LATENCY == 0)) ||
                         ((state_reg == ST_WAIT) && (cnt_reg == 4'd0)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = LAT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) state_next = ST_RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg    <= 1'b0;
      f3_reg    <= 3'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      we_reg    <= req_we;
      f3_reg    <= req_funct3;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
    end
  end

  assign acc_size = f3_size(acc_we, acc_f3);
  assign acc_idx  = acc_addr[AW-1:2];

  // Low address bits are forced to the access alignment.
  always_comb begin
    case (acc_size)
      SZ_BYTE: acc_off = acc_addr[1:0];
      SZ_HALF: acc_off = {acc_addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  logic misaligned;
  logic err_reg;
  assign misaligned = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                      ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
  assign acc_err    = !f3_legal(acc_we, acc_f3) || misaligned || (|acc_addr[31:AW]);
`else
  logic unused_addr;
  assign acc_err     = 1'b0;
  assign unused_addr = ^acc_addr[31:AW];
`endif

  // Byte enables and lane-replicated store data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign be[gi] = (acc_size == SZ_WORD) ||
                      ((acc_size == SZ_HALF) && (acc_off[1] == 1'(gi / 2))) ||
                      ((acc_size == SZ_BYTE) && (acc_off == 2'(gi)));
      assign wd[8*gi +: 8] = (acc_size == SZ_BYTE) ? acc_wdata[7:0] :
                             (acc_size == SZ_HALF) ? acc_wdata[8*(gi%2) +: 8] :
                                                     acc_wdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (fire && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[acc_idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) rd_word_reg <= mem[acc_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_off_reg  <= 2'b00;
      ld_size_reg <= SZ_WORD;
      ld_sign_reg <= 1'b0;
      ld_ok_reg   <= 1'b0;
    end else if (fire) begin
      ld_off_reg  <= acc_off;
      ld_size_reg <= acc_size;
      ld_sign_reg <= !acc_f3[2];
      ld_ok_reg   <= !acc_we && !acc_err;
    end
  end

`ifdef DMEM_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)       err_reg <= 1'b0;
    else if (fire) err_reg <= acc_err;
  end
  assign rsp_err = rsp_valid && err_reg;
`else
  assign rsp_err = 1'b0;
`endif

  dmem_load_align u_align (
    .word     (rd_word_reg),
    .offset   (ld_off_reg),
    .size     (ld_size_reg),
    .sign_ext (ld_sign_reg),
    .data     (aligned)
  );

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_rdata = (rsp_valid && ld_ok_reg) ? aligned : 32'd0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter SIZE_BYTES, default 4096, meaning memory capacity in bytes (power of two, >=16).
REQ-002 The block SHALL have parameter LATENCY, default 1, meaning extra wait cycles per access (0..15).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port: clk  in  1  clock, all logic on rising edge.
REQ-005 The block SHALL have port: rst  in  1  synchronous active-high reset.
REQ-006 The block SHALL have port: req_valid  in  1  request present.
REQ-007 The block SHALL have port: req_ready  out  1  block can accept a request.
REQ-008 The block SHALL have port: req_we  in  1  1 = store, 0 = load.
REQ-009 The block SHALL have port: req_funct3  in  3  RV32I access size/sign code.
REQ-010 The block SHALL have port: req_addr  in  32  byte address.
REQ-011 The block SHALL have port: req_wdata  in  32  store data, LSB-justified.
REQ-012 The block SHALL have port: rsp_valid  out  1  response present.
REQ-013 The block SHALL have port: rsp_ready  in  1  consumer accepts response.
REQ-014 The block SHALL have port: rsp_rdata  out  32  load result, extended; 0 for stores.
REQ-015 The block SHALL have port: rsp_err  out  1  access faulted.

Function
REQ-016 The block SHALL use FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 The block SHALL accept a request when req_valid and req_ready are both 1, and SHALL latch we, funct3, addr and wdata at acceptance.
REQ-018 On acceptance the block SHALL go IDLE->WAIT with counter=LATENCY-1 if LATENCY>0, else IDLE->RESP; WAIT SHALL decrement the counter and go to RESP after it reaches 0.
REQ-019 A request accepted in cycle T SHALL give rsp_valid=1 from cycle T+1+LATENCY.
REQ-020 The array access (store commit, load capture) SHALL occur on the edge entering RESP; only one access SHALL be outstanding.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1; the block SHALL then return to IDLE with rsp_valid=0 next cycle; rsp_ready in other states SHALL be ignored.
REQ-022 Loads SHALL decode funct3 as 000 LB sign-ext, 001 LH sign-ext, 010 LW, 100 LBU zero-ext, 101 LHU zero-ext, with byte lane selected by addr[1:0], little-endian.
REQ-023 Stores SHALL decode funct3 as 000 SB, 001 SH, 010 SW, writing only the addressed byte lanes via byte enables; other bytes SHALL be unchanged.
REQ-024 Storage SHALL be SIZE_BYTES/4 words of 32 bits, indexed by addr[log2(SIZE_BYTES)-1:2].
REQ-025 A load issued immediately after a store to the same address SHALL return the stored data.

Reset
REQ-026 When rst=1 the block SHALL set state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 0 while rst=1 and 1 on the first cycle after.
REQ-027 Reset during WAIT SHALL abort the access; a pending store SHALL NOT commit.
REQ-028 Reset SHALL NOT clear memory contents.

Configuration
REQ-029 With macro DMEM_ERR_CHECK_EN defined, a misaligned access (half with addr[0]=1, word with addr[1:0]!=0), addr>=SIZE_BYTES, or illegal funct3 SHALL complete with normal latency and rsp_err=1, rsp_rdata=0, no write.
REQ-030 Without DMEM_ERR_CHECK_EN, rsp_err SHALL be constant 0, addr SHALL wrap modulo SIZE_BYTES, low address bits SHALL be forced to access alignment, and illegal funct3 SHALL be treated as a word access.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state typedef.
REQ-032 Sub-module dmem_load_align SHALL contain the combinational lane select and sign/zero extension; byte-enable generation SHALL stay in dmem_ctrl.

Verification
REQ-033 With LATENCY=1, SW addr 0x10 data 0xDEADBEEF accepted at cycle T -> rsp_valid at T+2, rsp_rdata=0, rsp_err=0; then LW 0x10 -> 0xDEADBEEF.
REQ-034 SB 0x13 data 0x80, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
REQ-035 SH 0x12 data 0x1234 -> LHU 0x12 returns 0x00001234 and LH 0x10 returns 0xFFFFBEEF.
REQ-036 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 With DMEM_ERR_CHECK_EN, LW 0x11 or SW 0x1000 (SIZE_BYTES=4096) -> rsp_err=1, memory unchanged; without the macro, SW 0x1000 writes word 0.
REQ-038 Assert rst in WAIT during SW 0x20 data 0x55 (LATENCY=3) -> LW 0x20 afterwards returns the prior contents.
